// File: rtl/eth_tx_pkt_arbiter.sv
// N-channel Ethernet TX packet arbiter feeding a store-and-forward FIFO.
// Packets reach the MAC only once complete, except through the oversize cut-through escape.
module eth_tx_pkt_arbiter #(
  parameter int NCH       = 4,
  parameter int DW        = 32,
  parameter int AW        = 9,
  parameter int MAX_PKTS  = 15,
  parameter int PRIO_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NCH*DW-1:0]             i_ch_data,
  input  logic [NCH-1:0]                i_ch_vld,
  input  logic [NCH-1:0]                i_ch_sop,
  input  logic [NCH-1:0]                i_ch_eop,
  output logic [NCH-1:0]                o_ch_rdy,
  output logic [DW-1:0]                 o_tx_data,
  output logic                          o_tx_vld,
  output logic                          o_tx_sop,
  output logic                          o_tx_eop,
  input  logic                          i_tx_rdy,
  output logic [NCH-1:0]                o_grant,
  output logic [$clog2(MAX_PKTS+1)-1:0] o_pkt_cnt,
  output logic [7:0]                    o_orphan_cnt
);

  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PCW = $clog2(MAX_PKTS + 1);
  localparam int FW  = DW + 2;
  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_BUSY  = 1'b1;
  localparam logic [AW:0]    FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [PCW-1:0] MAX_CNT  = PCW'(MAX_PKTS);

  logic [0:0]     state_r;
  logic [NCH-1:0] grant_r;
  logic [IW-1:0]  gidx_r;
  logic [IW-1:0]  rr_ptr_r;
  logic [FW-1:0]  mem_r [2**AW];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    level_r;
  logic [PCW-1:0] pkt_cnt_r;
  logic           ct_flag_r;
  logic [7:0]     orphan_cnt_r;

  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic           room_s;
  logic           wr_en_s;
  logic           wr_eop_s;
  logic           rd_en_s;
  logic           rd_eop_s;
  logic           tx_vld_s;
  logic           pick_vld_s;
  logic [IW-1:0]  pick_idx_s;
  logic [IW-1:0]  base_s;
  logic [IW:0]    sum_s;
  logic [IW-1:0]  idx_s;
  logic [NCH-1:0] cand_s;
  logic [NCH-1:0] rdy_s;
  logic [NCH-1:0] orphan_s;
  logic [3:0]     orphan_n_s;
  logic [8:0]     orphan_sum_s;
  logic [FW-1:0]  head_s;
  logic [FW-1:0]  wr_word_s;

  assign fifo_full_s  = (level_r == FULL_LVL);
  assign fifo_empty_s = (level_r == {(AW+1){1'b0}});
  assign room_s       = ~fifo_full_s & (pkt_cnt_r != MAX_CNT);
  assign cand_s       = i_ch_vld & i_ch_sop;
  assign base_s       = (PRIO_MODE != 0) ? {IW{1'b0}} : rr_ptr_r;

  // Winner search: walk offsets from the far end so the closest candidate to base wins.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = {IW{1'b0}};
    sum_s      = {(IW+1){1'b0}};
    idx_s      = {IW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      sum_s      = {1'b0, base_s} + (IW+1)'(i);
      idx_s      = (sum_s >= (IW+1)'(NCH)) ? IW'(sum_s - (IW+1)'(NCH)) : IW'(sum_s);
      pick_vld_s = pick_vld_s | cand_s[idx_s];
      pick_idx_s = cand_s[idx_s] ? idx_s : pick_idx_s;
    end
  end

  // Ready generation: granted channel while BUSY, sop-less (orphan) beats while IDLE.
  always_comb begin
    rdy_s    = {NCH{1'b0}};
    orphan_s = {NCH{1'b0}};
    if (state_r == ST_BUSY) begin
      rdy_s = grant_r & {NCH{room_s}};
    end else begin
      orphan_s = i_ch_vld & ~i_ch_sop;
      rdy_s    = orphan_s;
    end
  end

  // Orphan beat count for this cycle, added with saturation below.
  always_comb begin
    orphan_n_s = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      orphan_n_s = orphan_n_s + {3'b000, orphan_s[i]};
    end
    orphan_sum_s = {1'b0, orphan_cnt_r} + {5'b00000, orphan_n_s};
  end

  assign wr_word_s = {i_ch_data[gidx_r*DW +: DW], i_ch_sop[gidx_r], i_ch_eop[gidx_r]};
  assign wr_en_s   = (state_r == ST_BUSY) & |(i_ch_vld & rdy_s);
  assign wr_eop_s  = wr_en_s & i_ch_eop[gidx_r];
  assign head_s    = mem_r[rd_ptr_r];
  // Without a complete packet the head is held back unless the packet outgrew the FIFO.
  assign tx_vld_s  = ~fifo_empty_s & ((pkt_cnt_r != {PCW{1'b0}}) | ct_flag_r);
  assign rd_en_s   = tx_vld_s & i_tx_rdy;
  assign rd_eop_s  = rd_en_s & head_s[0];

  assign o_ch_rdy     = rdy_s & {NCH{rst_n}};
  assign o_tx_vld     = tx_vld_s;
  assign o_tx_data    = tx_vld_s ? head_s[FW-1:2] : {DW{1'b0}};
  assign o_tx_sop     = tx_vld_s & head_s[1];
  assign o_tx_eop     = tx_vld_s & head_s[0];
  assign o_grant      = grant_r;
  assign o_pkt_cnt    = pkt_cnt_r;
  assign o_orphan_cnt = orphan_cnt_r;

  // Arbiter FSM: one grant per packet, released on the accepted eop beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      grant_r  <= {NCH{1'b0}};
      gidx_r   <= {IW{1'b0}};
      rr_ptr_r <= {IW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_vld_s) begin
            state_r  <= ST_BUSY;
            grant_r  <= NCH'(1) << pick_idx_s;
            gidx_r   <= pick_idx_s;
            rr_ptr_r <= (pick_idx_s == IW'(NCH - 1)) ? {IW{1'b0}} : pick_idx_s + IW'(1);
          end
        end
        ST_BUSY: begin
          if (wr_eop_s) begin
            state_r <= ST_IDLE;
            grant_r <= {NCH{1'b0}};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= {NCH{1'b0}};
        end
      endcase
    end
  end

  // FIFO storage array; contents need no reset since the level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // FIFO pointers, level, packet count, cut-through flag and orphan counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      level_r      <= {(AW+1){1'b0}};
      pkt_cnt_r    <= {PCW{1'b0}};
      ct_flag_r    <= 1'b0;
      orphan_cnt_r <= 8'd0;
    end else begin
      wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, wr_en_s};
      rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, rd_en_s};
      level_r  <= level_r + {{AW{1'b0}}, wr_en_s} - {{AW{1'b0}}, rd_en_s};
      case ({wr_eop_s, rd_eop_s})
        2'b10:   pkt_cnt_r <= pkt_cnt_r + PCW'(1);
        2'b01:   pkt_cnt_r <= pkt_cnt_r - PCW'(1);
        default: pkt_cnt_r <= pkt_cnt_r;
      endcase
      if (rd_eop_s) begin
        ct_flag_r <= 1'b0;
      end else if (fifo_full_s && (pkt_cnt_r == {PCW{1'b0}})) begin
        ct_flag_r <= 1'b1;
      end
      orphan_cnt_r <= orphan_sum_s[8] ? 8'hFF : orphan_sum_s[7:0];
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// Bench for eth_tx_pkt_arbiter: per-channel source queues, a round-robin packet-order
// model and a received-beat log compared against the expected MAC stream.
module tb_eth_tx_pkt_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int PCW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*DW-1:0] i_ch_data;
  logic [NCH-1:0]    i_ch_vld, i_ch_sop, i_ch_eop, o_ch_rdy;
  logic [DW-1:0]     o_tx_data;
  logic              o_tx_vld, o_tx_sop, o_tx_eop;
  logic              i_tx_rdy = 1'b1;
  logic [NCH-1:0]    o_grant;
  logic [PCW-1:0]    o_pkt_cnt;
  logic [7:0]        o_orphan_cnt;

  always #5 clk = ~clk;

  eth_tx_pkt_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .MAX_PKTS(15), .PRIO_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_ch_data(i_ch_data), .i_ch_vld(i_ch_vld),
    .i_ch_sop(i_ch_sop), .i_ch_eop(i_ch_eop), .o_ch_rdy(o_ch_rdy),
    .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld), .o_tx_sop(o_tx_sop),
    .o_tx_eop(o_tx_eop), .i_tx_rdy(i_tx_rdy), .o_grant(o_grant),
    .o_pkt_cnt(o_pkt_cnt), .o_orphan_cnt(o_orphan_cnt));

  logic [DW+1:0] chbuf [NCH][1024];
  int            hd [NCH];
  int            tl [NCH];
  int            pst [NCH][16];
  int            pln [NCH][16];
  int            pn [NCH];
  logic [DW+1:0] expq [$];
  logic [DW+1:0] rxq [$];
  int            n_chk = 0, n_fail = 0, cyc = 0;
  int            eop_acc_cyc = -1, first_vld_cyc = -1;
  logic [PCW-1:0] cnt_at_vld;
  bit            rnd_rdy = 1'b0;
  int            ptr = 0;

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      if (hd[k] < tl[k]) begin
        i_ch_vld[k] = 1'b1;
        i_ch_data[k*DW +: DW] = chbuf[k][hd[k]][DW+1:2];
        i_ch_sop[k] = chbuf[k][hd[k]][1];
        i_ch_eop[k] = chbuf[k][hd[k]][0];
      end else begin
        i_ch_vld[k] = 1'b0;
        i_ch_data[k*DW +: DW] = '0;
        i_ch_sop[k] = 1'b0;
        i_ch_eop[k] = 1'b0;
      end
    end
  endtask

  // One clock: sample at the falling edge, update sources just after the rising edge.
  task automatic cycle();
    logic [NCH-1:0] acc;
    @(negedge clk);
    acc = i_ch_vld & o_ch_rdy;
    if (o_tx_vld && first_vld_cyc < 0) begin
      first_vld_cyc = cyc;
      cnt_at_vld = o_pkt_cnt;
    end
    if (o_tx_vld && i_tx_rdy) rxq.push_back({o_tx_data, o_tx_sop, o_tx_eop});
    for (int k = 0; k < NCH; k++)
      if (acc[k] && chbuf[k][hd[k]][0]) eop_acc_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NCH; k++) if (acc[k]) hd[k]++;
    if (rnd_rdy) i_tx_rdy = ($urandom_range(3) != 0);
    drive();
  endtask

  task automatic add_pkt(input int k, input int len);
    pst[k][pn[k]] = tl[k];
    pln[k][pn[k]] = len;
    pn[k]++;
    for (int b = 0; b < len; b++) begin
      chbuf[k][tl[k]] = {$urandom(), (b == 0), (b == len - 1)};
      tl[k]++;
    end
  endtask

  task automatic add_beat(input int k, input bit sop, input bit eop);
    chbuf[k][tl[k]] = {$urandom(), sop, eop};
    tl[k]++;
  endtask

  // Expected MAC order: repeatedly serve the first pending channel at or after the pointer.
  task automatic model_order();
    int  taken [NCH];
    bit  any;
    for (int k = 0; k < NCH; k++) taken[k] = 0;
    do begin
      any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (ptr + i) % NCH;
        if (!any && taken[k] < pn[k]) begin
          any = 1'b1;
          for (int b = 0; b < pln[k][taken[k]]; b++)
            expq.push_back(chbuf[k][pst[k][taken[k]] + b]);
          taken[k]++;
          ptr = (k + 1) % NCH;
        end
      end
    end while (any);
    for (int k = 0; k < NCH; k++) pn[k] = 0;
  endtask

  function automatic int first_diff();
    if (rxq.size() != expq.size()) return (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < rxq.size(); i++) if (rxq[i] !== expq[i]) return i;
    return -1;
  endfunction

  task automatic drain(input int maxc, output bit ok);
    bit idle;
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      cycle();
      idle = 1'b1;
      for (int k = 0; k < NCH; k++) if (hd[k] != tl[k]) idle = 1'b0;
      if (idle && rxq.size() >= expq.size()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rnd_rdy = 1'b0;
    i_tx_rdy = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      hd[k] = 0; tl[k] = 0; pn[k] = 0;
    end
    drive();
    expq.delete();
    rxq.delete();
    ptr = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (o_tx_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", o_tx_vld); end
    n_chk++; if (o_grant !== '0) begin n_fail++; $display("FAIL reset_grant got %b want 0", o_grant); end
    n_chk++; if (o_pkt_cnt !== '0) begin n_fail++; $display("FAIL reset_pkt_cnt got %0d want 0", o_pkt_cnt); end
    n_chk++; if (o_orphan_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_orphan got %0d want 0", o_orphan_cnt); end
    n_chk++; if (o_ch_rdy !== '0 || o_tx_data !== '0) begin n_fail++; $display("FAIL reset_rdy_data got %b/%h want 0/0", o_ch_rdy, o_tx_data); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    add_pkt(1, 4);
    model_order();
    drive();
    eop_acc_cyc = -1;
    first_vld_cyc = -1;
    drain(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout got rx=%0d want %0d", rxq.size(), expq.size()); end
    n_chk++; if (first_vld_cyc - eop_acc_cyc !== 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", first_vld_cyc - eop_acc_cyc); end
    n_chk++; if (cnt_at_vld !== 4'd1) begin n_fail++; $display("FAIL single_cnt_at_vld got %0d want 1", cnt_at_vld); end
    n_chk++; if (first_diff() !== -1) begin n_fail++; $display("FAIL single_stream got diff@%0d want none", first_diff()); end
    n_chk++; if (o_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL single_cnt_end got %0d want 0", o_pkt_cnt); end
  endtask

  task automatic test_rr_order();
    bit ok;
    int s0, s2, s3;
    do_reset();
    s0 = tl[0]; s2 = tl[2]; s3 = tl[3];
    add_pkt(0, 3); add_pkt(2, 3); add_pkt(3, 3);
    model_order();
    drive();
    drain(300, ok);
    n_chk++; if (!ok || first_diff() !== -1) begin n_fail++; $display("FAIL rr_round1 got ok=%0d diff@%0d want ok=1 none", ok, first_diff()); end
    n_chk++;
    if (rxq.size() != 9 || rxq[0] !== chbuf[0][s0] || rxq[3] !== chbuf[2][s2] || rxq[6] !== chbuf[3][s3]) begin
      n_fail++; $display("FAIL rr_order1 got size %0d want order ch0,ch2,ch3", rxq.size());
    end
    rxq.delete(); expq.delete();
    add_pkt(2, 2);
    model_order();
    drive();
    drain(300, ok);
    rxq.delete(); expq.delete();
    s0 = tl[0]; s2 = tl[2]; s3 = tl[3];
    add_pkt(0, 3); add_pkt(2, 3); add_pkt(3, 3);
    model_order();
    drive();
    drain(300, ok);
    n_chk++;
    if (!ok || rxq.size() != 9 || rxq[0] !== chbuf[3][s3] || rxq[3] !== chbuf[0][s0] || rxq[6] !== chbuf[2][s2]) begin
      n_fail++; $display("FAIL rr_order2 got size %0d want order ch3,ch0,ch2", rxq.size());
    end
  endtask

  task automatic test_random_traffic();
    bit ok;
    int tot;
    rnd_rdy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rxq.delete(); expq.delete();
      tot = 0;
      for (int k = 0; k < NCH; k++) begin
        int np;
        np = $urandom_range(2);
        for (int p = 0; p < np; p++) begin add_pkt(k, $urandom_range(6, 1)); tot++; end
      end
      if (tot == 0) add_pkt($urandom_range(NCH - 1), 2);
      model_order();
      drive();
      drain(2000, ok);
      n_chk++; if (!ok || first_diff() !== -1) begin n_fail++; $display("FAIL random_round%0d got ok=%0d diff@%0d want ok=1 none", r, ok, first_diff()); end
    end
    rnd_rdy = 1'b0;
    i_tx_rdy = 1'b1;
  endtask

  task automatic test_back_pressure();
    bit ok;
    do_reset();
    i_tx_rdy = 1'b0;
    for (int p = 0; p < 16; p++) add_pkt(0, 1);
    model_order();
    drive();
    repeat (50) cycle();
    n_chk++; if (o_pkt_cnt !== 4'd15) begin n_fail++; $display("FAIL bp_cnt got %0d want 15", o_pkt_cnt); end
    n_chk++; if (o_ch_rdy !== '0 || hd[0] !== 15) begin n_fail++; $display("FAIL bp_stall got rdy=%b acc=%0d want 0/15", o_ch_rdy, hd[0]); end
    i_tx_rdy = 1'b1;
    drain(300, ok);
    n_chk++; if (!ok || first_diff() !== -1) begin n_fail++; $display("FAIL bp_drain got ok=%0d diff@%0d want ok=1 none", ok, first_diff()); end
  endtask

  task automatic test_cut_through();
    bit ok;
    do_reset();
    i_tx_rdy = 1'b0;
    add_pkt(3, 20);
    model_order();
    drive();
    repeat (30) cycle();
    n_chk++; if (hd[3] !== 16 || o_ch_rdy !== '0) begin n_fail++; $display("FAIL ct_full got acc=%0d rdy=%b want 16/0", hd[3], o_ch_rdy); end
    n_chk++; if (o_tx_vld !== 1'b1 || o_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL ct_escape got vld=%b cnt=%0d want 1/0", o_tx_vld, o_pkt_cnt); end
    i_tx_rdy = 1'b1;
    drain(300, ok);
    n_chk++; if (!ok || first_diff() !== -1) begin n_fail++; $display("FAIL ct_stream got ok=%0d diff@%0d want ok=1 none", ok, first_diff()); end
    rxq.delete(); expq.delete();
    i_tx_rdy = 1'b0;
    add_beat(0, 1'b1, 1'b0);
    drive();
    repeat (5) cycle();
    n_chk++; if (o_tx_vld !== 1'b0) begin n_fail++; $display("FAIL ct_cleared got vld=%b want 0", o_tx_vld); end
    add_beat(0, 1'b0, 1'b1);
    expq.push_back(chbuf[0][0]);
    expq.push_back(chbuf[0][1]);
    drive();
    repeat (4) cycle();
    n_chk++; if (o_tx_vld !== 1'b1 || o_pkt_cnt !== 4'd1) begin n_fail++; $display("FAIL ct_after got vld=%b cnt=%0d want 1/1", o_tx_vld, o_pkt_cnt); end
    i_tx_rdy = 1'b1;
    drain(100, ok);
    n_chk++; if (!ok || first_diff() !== -1) begin n_fail++; $display("FAIL ct_after_stream got diff@%0d want none", first_diff()); end
  endtask

  task automatic test_orphans();
    do_reset();
    for (int b = 0; b < 3; b++) add_beat(2, 1'b0, 1'b0);
    drive();
    repeat (10) cycle();
    n_chk++; if (o_orphan_cnt !== 8'd3 || hd[2] !== 3) begin n_fail++; $display("FAIL orphan_cnt got %0d acc=%0d want 3/3", o_orphan_cnt, hd[2]); end
    n_chk++; if (o_tx_vld !== 1'b0 || o_pkt_cnt !== '0 || o_grant !== '0 || rxq.size() != 0) begin
      n_fail++; $display("FAIL orphan_nowrite got vld=%b cnt=%0d grant=%b want 0/0/0", o_tx_vld, o_pkt_cnt, o_grant);
    end
    for (int b = 0; b < 260; b++) add_beat(1, 1'b0, (b % 2) == 1);
    drive();
    repeat (270) cycle();
    n_chk++; if (o_orphan_cnt !== 8'd255) begin n_fail++; $display("FAIL orphan_sat got %0d want 255", o_orphan_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int n;
    do_reset();
    add_pkt(1, 5);
    pn[1] = 0;
    drive();
    n = 0;
    while (hd[1] < 2 && n < 20) begin cycle(); n++; end
    n_chk++; if (hd[1] !== 2) begin n_fail++; $display("FAIL mid_progress got %0d want 2", hd[1]); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (o_tx_vld !== 1'b0 || o_grant !== '0 || o_ch_rdy !== '0 || o_pkt_cnt !== '0 || o_orphan_cnt !== 8'd0 || o_tx_data !== '0) begin
      n_fail++; $display("FAIL mid_async got vld=%b grant=%b rdy=%b want all 0", o_tx_vld, o_grant, o_ch_rdy);
    end
    do_reset();
    #1;
    n_chk++; if (o_tx_vld !== 1'b0 || o_pkt_cnt !== '0) begin n_fail++; $display("FAIL mid_empty got vld=%b cnt=%0d want 0/0", o_tx_vld, o_pkt_cnt); end
    add_pkt(1, 5);
    model_order();
    drive();
    drain(200, ok);
    n_chk++; if (!ok || first_diff() !== -1) begin n_fail++; $display("FAIL mid_next_pkt got ok=%0d diff@%0d want ok=1 none", ok, first_diff()); end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin hd[k] = 0; tl[k] = 0; pn[k] = 0; end
    drive();
    test_reset();
    test_single();
    test_rr_order();
    test_random_traffic();
    test_back_pressure();
    test_cut_through();
    test_orphans();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
